sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Parametrised single-clock FIFO. It is the general buffering primitive between pipeline stages, bus adapters and UART/peripheral datapaths. It adds the following over the basic FIFO:
- selectable first-word-fall-through (FWFT) or registered-read mode
- programmable almost-full/almost-empty thresholds
- fill count
- synchronous flush
- sticky overflow/underflow error flags

Parameters:
DATA_WIDTH, 32, width of each entry in bits (>=1)
DEPTH, 32, number of entries; power of two, >=2
FWFT, 0, 0 = registered read (data one cycle after read), 1 = head word presented on o_data while !o_empty
AF_THRESH, DEPTH-2, o_almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, o_almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous, active-low reset
i_flush  input  1  synchronous clear of contents and error flags
i_write_en  input  1  write request
i_data  input  DATA_WIDTH  write data
i_read_en  input  1  read request (FWFT=1: acknowledge/pop of head word)
o_data  output  DATA_WIDTH  read data
o_valid  output  1  FWFT=0: o_data valid this cycle (1-cycle pulse); FWFT=1: equals !o_empty
o_full  output  1  count == DEPTH
o_empty  output  1  count == 0
o_almost_full  output  1  count >= AF_THRESH
o_almost_empty  output  1  count <= AE_THRESH
o_count  output  $clog2(DEPTH)+1  current number of stored entries
o_overflow  output  1  sticky: write attempted while full and not accepted
o_underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset and flush priority: reset (i_rst==0 at edge) > flush > read/write.
- Reset state:
  - pointers = 0, count = 0
  - o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0
  - o_valid=0, o_data=0, o_overflow=0, o_underflow=0
  - Storage array is not reset.
- Flush: same register effect as reset, except o_data holds its value. Any write/read in the flush cycle is discarded and does not set error flags.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Count is a separate registered counter of $clog2(DEPTH)+1 bits. All status outputs are registered/derived from count. No combinational path from i_write_en/i_read_en to status.
- Read accept: rd_acc = i_read_en && !o_empty.
- Write accept: wr_acc = i_write_en && (!o_full || rd_acc). Simultaneous read and write when full is legal: both are accepted and count is unchanged.
- Empty corner cases:
  - Simultaneous read and write when empty: write accepted, read rejected, o_underflow set.
  - Count update: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- Error flags:
  - o_overflow set on i_write_en && !wr_acc.
  - o_underflow set on i_read_en && o_empty.
  - Both stay set until reset or flush.
- Write latency: an entry written at edge N is readable at edge N+1. o_empty falls one cycle after the first accepted write.
- FWFT=0 read: on rd_acc at edge N, o_data = mem[read_ptr] is registered and visible after edge N, and o_valid=1 for exactly that cycle. Without rd_acc, o_valid=0 and o_data holds.
- FWFT=1 read:
  - o_data = mem[read_ptr] continuously; o_valid = !o_empty.
  - rd_acc advances the pointer, so the next word appears after the edge.
  - o_data content is don't-care while empty.
- Ordering: strict FIFO order is preserved across pointer wrap-around.
- Threshold parameters outside their legal range are an elaboration error (static assertion).
- FORMAL build: count never exceeds DEPTH; o_full and o_empty are never both 1; count == (write_ptr − read_ptr) mod DEPTH, except count==DEPTH when the pointers are equal and the FIFO is full.

Test Plan:
Parameters for all scenarios: DATA_WIDTH=8, DEPTH=8, AF=6, AE=2.
- Reset: hold i_rst=0 for 2 cycles with i_write_en=1 → o_count=0, o_empty=1, o_almost_empty=1, no flags; after release, o_empty=1 until the first write.
- Fill/drain, FWFT=0: write 0x10..0x17 → o_full=1 after 8th edge, o_almost_full from count 6. Then a 9th write → o_overflow=1 and count stays 8. Read 8 → o_data 0x10..0x17 each with a 1-cycle o_valid pulse. A 9th read → o_underflow=1.
- FWFT=1 latency: single write 0xA5 at edge N → o_empty=0, o_valid=1, o_data=0xA5 after edge N. Read at N+1 → o_empty=1 after N+1.
- Simultaneous full read+write: at count 8 assert both with i_data=0x99 → count stays 8, no overflow. 0x99 is read out last after the 7 remaining older entries.
- Wrap-around: 20 interleaved write/read bursts of random sizes ≤8 against a scoreboard → exact ordering, and o_count matches the model every cycle.
- Flush mid-operation: count=5 with o_overflow=1, pulse i_flush together with i_write_en → count=0, o_empty=1, flags cleared, the written word is discarded.

Source files
------------

// File: rtl/sync_fifo_if.sv
// Handshake, data and status bundle for sync_fifo. The FIFO takes the slave view and
// the producer/consumer takes the master view.
interface sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  i_flush;
  logic                  i_write_en;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_read_en;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_full;
  logic                  o_empty;
  logic                  o_almost_full;
  logic                  o_almost_empty;
  logic [CntW-1:0]       o_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport slave (
    input  i_flush, i_write_en, i_data, i_read_en,
    output o_data, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_overflow, o_underflow
  );

  modport master (
    output i_flush, i_write_en, i_data, i_read_en,
    input  o_data, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read, fill count,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  sync_fifo_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfTh = CntW'(AF_THRESH);
  localparam logic [CntW-1:0] AeTh = CntW'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo: DATA_WIDTH must be >= 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  empty, full, rd_acc, wr_acc;

  assign empty  = (count_q == '0);
  assign full   = (count_q == Full);
  assign rd_acc = bus.i_read_en && !empty;
  // A read in the same cycle frees the slot, so a full FIFO still takes the write.
  assign wr_acc = bus.i_write_en && (!full || rd_acc);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (bus.i_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PtrW'(1);
      if (rd_acc) begin
        rptr_d  = rptr_q + PtrW'(1);
        rdata_d = mem_q[rptr_q];
        valid_d = 1'b1;
      end
      if (wr_acc && !rd_acc) count_d = count_q + CntW'(1);
      if (rd_acc && !wr_acc) count_d = count_q - CntW'(1);
      if (bus.i_write_en && !wr_acc) ovf_d = 1'b1;
      if (bus.i_read_en && empty)    unf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; writes are blocked during reset and flush cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst && !bus.i_flush && wr_acc) mem_q[wptr_q] <= bus.i_data;
  end

  assign bus.o_data         = (FWFT != 0) ? mem_q[rptr_q] : rdata_q;
  assign bus.o_valid        = (FWFT != 0) ? !empty : valid_q;
  assign bus.o_full         = full;
  assign bus.o_empty        = empty;
  assign bus.o_almost_full  = (count_q >= AfTh);
  assign bus.o_almost_empty = (count_q <= AeTh);
  assign bus.o_count        = count_q;
  assign bus.o_overflow     = ovf_q;
  assign bus.o_underflow    = unf_q;

`ifdef FORMAL
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      assert (count_q <= Full);
      assert (!(full && empty));
      assert ((count_q == CntW'(wptr_q - rptr_q)) || (full && wptr_q == rptr_q));
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a registered-read and an FWFT instance (8x8, AF=6, AE=2)
// checked against queue scoreboards.
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) bus0 ();
  sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) bus1 ();

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_dut0 (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus0.slave)
  );

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_dut1 (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus1.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int mcnt;
  logic [7:0] last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus0.i_flush = 0; bus0.i_write_en = 0; bus0.i_read_en = 0; bus0.i_data = '0;
    bus1.i_flush = 0; bus1.i_write_en = 0; bus1.i_read_en = 0; bus1.i_data = '0;
  endtask

  // Registered-read pop: one pulse with the expected head word, then an idle cycle.
  task automatic read0(input string tag);
    bus0.i_read_en = 1;
    tick();
    bus0.i_read_en = 0;
    last = q0.pop_front();
    mcnt--;
    check({tag, "_valid"}, 32'(bus0.o_valid), 1);
    check({tag, "_data"}, 32'(bus0.o_data), 32'(last));
    check({tag, "_count"}, 32'(bus0.o_count), 32'(mcnt));
    tick();
    check({tag, "_valid_gap"}, 32'(bus0.o_valid), 0);
    check({tag, "_data_hold"}, 32'(bus0.o_data), 32'(last));
  endtask

  initial begin
    idle_all();
    // Reset held two cycles with writes requested.
    rst_n = 0;
    bus0.i_write_en = 1; bus0.i_data = 8'h55;
    bus1.i_write_en = 1; bus1.i_data = 8'h55;
    tick();
    tick();
    check("rst_count", 32'(bus0.o_count), 0);
    check("rst_empty", 32'(bus0.o_empty), 1);
    check("rst_full", 32'(bus0.o_full), 0);
    check("rst_ae", 32'(bus0.o_almost_empty), 1);
    check("rst_af", 32'(bus0.o_almost_full), 0);
    check("rst_valid", 32'(bus0.o_valid), 0);
    check("rst_data", 32'(bus0.o_data), 0);
    check("rst_ovf", 32'(bus0.o_overflow), 0);
    check("rst_unf", 32'(bus0.o_underflow), 0);
    check("rst_fwft_valid", 32'(bus1.o_valid), 0);
    idle_all();
    rst_n = 1;
    tick();
    check("post_rst_empty0", 32'(bus0.o_empty), 1);
    check("post_rst_empty1", 32'(bus1.o_empty), 1);

    // Fill registered-read FIFO.
    mcnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus0.i_write_en = 1; bus0.i_data = 8'(8'h10 + i);
      tick();
      q0.push_back(8'(8'h10 + i));
      mcnt++;
      check("fill_count", 32'(bus0.o_count), 32'(mcnt));
      check("fill_full", 32'(bus0.o_full), 32'(mcnt == 8));
      check("fill_af", 32'(bus0.o_almost_full), 32'(mcnt >= 6));
      check("fill_ae", 32'(bus0.o_almost_empty), 32'(mcnt <= 2));
      check("fill_empty", 32'(bus0.o_empty), 0);
    end
    bus0.i_data = 8'h18;
    tick();
    bus0.i_write_en = 0;
    check("ovf_flag", 32'(bus0.o_overflow), 1);
    check("ovf_count", 32'(bus0.o_count), 8);
    check("ovf_unf", 32'(bus0.o_underflow), 0);

    for (int i = 0; i < 8; i++) read0("drain");
    check("drain_empty", 32'(bus0.o_empty), 1);
    check("pre_unf", 32'(bus0.o_underflow), 0);
    bus0.i_read_en = 1;
    tick();
    bus0.i_read_en = 0;
    check("unf_flag", 32'(bus0.o_underflow), 1);
    check("unf_valid", 32'(bus0.o_valid), 0);
    check("unf_count", 32'(bus0.o_count), 0);

    // Flush clears flags and keeps o_data.
    bus0.i_flush = 1;
    tick();
    bus0.i_flush = 0;
    check("flush0_ovf", 32'(bus0.o_overflow), 0);
    check("flush0_unf", 32'(bus0.o_underflow), 0);
    check("flush0_data_hold", 32'(bus0.o_data), 32'(8'h17));

    // Simultaneous read+write while full.
    for (int i = 0; i < 8; i++) begin
      bus0.i_write_en = 1; bus0.i_data = 8'(8'h20 + i);
      tick();
      q0.push_back(8'(8'h20 + i));
      mcnt++;
    end
    check("rw_full_pre", 32'(bus0.o_full), 1);
    bus0.i_data = 8'h99; bus0.i_read_en = 1;
    tick();
    bus0.i_write_en = 0; bus0.i_read_en = 0;
    last = q0.pop_front();
    q0.push_back(8'h99);
    check("rw_full_count", 32'(bus0.o_count), 8);
    check("rw_full_ovf", 32'(bus0.o_overflow), 0);
    check("rw_full_valid", 32'(bus0.o_valid), 1);
    check("rw_full_data", 32'(bus0.o_data), 32'(last));
    for (int i = 0; i < 8; i++) read0("rw_drain");
    check("rw_last_is_99", 32'(last), 32'(8'h99));
    check("rw_empty", 32'(bus0.o_empty), 1);

    // FWFT latency.
    bus1.i_write_en = 1; bus1.i_data = 8'hA5;
    tick();
    bus1.i_write_en = 0;
    check("fwft_empty", 32'(bus1.o_empty), 0);
    check("fwft_valid", 32'(bus1.o_valid), 1);
    check("fwft_data", 32'(bus1.o_data), 32'(8'hA5));
    bus1.i_read_en = 1;
    tick();
    bus1.i_read_en = 0;
    check("fwft_pop_empty", 32'(bus1.o_empty), 1);
    check("fwft_pop_valid", 32'(bus1.o_valid), 0);

    // Wrap-around bursts on the FWFT instance.
    mcnt = 0;
    for (int b = 0; b < 20; b++) begin
      int w, r;
      logic [7:0] d;
      w = int'($urandom_range(1, 8));
      if (w > 8 - mcnt) w = 8 - mcnt;
      for (int k = 0; k < w; k++) begin
        d = 8'($urandom);
        bus1.i_write_en = 1; bus1.i_data = d;
        tick();
        q1.push_back(d);
        mcnt++;
        check("wrap_wr_count", 32'(bus1.o_count), 32'(mcnt));
      end
      bus1.i_write_en = 0;
      r = int'($urandom_range(1, 8));
      if (r > mcnt) r = mcnt;
      if (b == 19) r = mcnt;
      for (int k = 0; k < r; k++) begin
        check("wrap_valid", 32'(bus1.o_valid), 1);
        check("wrap_data", 32'(bus1.o_data), 32'(q1[0]));
        bus1.i_read_en = 1;
        tick();
        void'(q1.pop_front());
        mcnt--;
        check("wrap_rd_count", 32'(bus1.o_count), 32'(mcnt));
      end
      bus1.i_read_en = 0;
    end
    check("wrap_end_empty", 32'(bus1.o_empty), 1);

    // Flush mid-operation with count 5 and overflow set.
    mcnt = 0;
    for (int i = 0; i < 8; i++) begin
      bus0.i_write_en = 1; bus0.i_data = 8'(8'h30 + i);
      tick();
      q0.push_back(8'(8'h30 + i));
      mcnt++;
    end
    bus0.i_data = 8'h38;
    tick();
    bus0.i_write_en = 0;
    for (int i = 0; i < 3; i++) read0("pre_flush");
    check("pre_flush_count", 32'(bus0.o_count), 5);
    check("pre_flush_ovf", 32'(bus0.o_overflow), 1);
    bus0.i_flush = 1; bus0.i_write_en = 1; bus0.i_data = 8'hEE;
    tick();
    bus0.i_flush = 0; bus0.i_write_en = 0;
    q0.delete();
    mcnt = 0;
    check("flush_count", 32'(bus0.o_count), 0);
    check("flush_empty", 32'(bus0.o_empty), 1);
    check("flush_ovf", 32'(bus0.o_overflow), 0);
    check("flush_unf", 32'(bus0.o_underflow), 0);
    check("flush_valid", 32'(bus0.o_valid), 0);
    bus0.i_write_en = 1; bus0.i_data = 8'h42;
    tick();
    bus0.i_write_en = 0;
    q0.push_back(8'h42);
    mcnt++;
    read0("post_flush");
    check("post_flush_empty", 32'(bus0.o_empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
